// File: rtl/store_wbuf_pkg.sv
// Shared types and helpers for the store write buffer.
package store_wbuf_pkg;

    localparam int WBUF_ADDR_W = 6;
    localparam int WBUF_DATA_W = 16;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [WBUF_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Advance a circular pointer, wrapping back to zero after depth-1.
    function automatic logic [7:0] wbuf_ptr_inc(input logic [7:0] ptr, input logic [7:0] depth);
        logic [7:0] nxt;
        if (ptr == depth - 8'd1) begin
            nxt = 8'd0;
        end else begin
            nxt = ptr + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wbuf_fwd_match.sv
// Youngest-match search over the occupied slots of the circular entry array.
// Used for load forwarding and, when merging is enabled, store merge detection.
module wbuf_fwd_match
    import store_wbuf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wbuf_entry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]        head,
    input  logic [CNT_W-1:0]        count,
    input  logic [WBUF_ADDR_W-1:0]  key,
    input  logic                    skip_head,
    output logic                    hit,
    output logic [WBUF_DATA_W-1:0]  data,
    output logic [PTR_W-1:0]        idx
);

    logic [PTR_W-1:0] pos_s;
    logic [CNT_W-1:0] off_s;
    logic             match_s;

    // Walk oldest to youngest so the last match found is the youngest one
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        idx     = '0;
        pos_s   = '0;
        off_s   = '0;
        match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off_s   = CNT_W'(i);
            pos_s   = head + PTR_W'(i);
            match_s = (off_s < count) &&
                      !(skip_head && (off_s == {CNT_W{1'b0}})) &&
                      (entries[pos_s].addr == key);
            hit     = hit | match_s;
            data    = match_s ? entries[pos_s].data : data;
            idx     = match_s ? pos_s : idx;
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// FIFO store write buffer in front of the 64x16 data memory, with load forwarding.
// Build option STORE_WBUF_MERGE_EN: stores hitting a buffered address overwrite it in place.
module store_write_buffer
    import store_wbuf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WBUF_ADDR_W,
    parameter int DATA_W = WBUF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t [DEPTH-1:0] entries_r;
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [CNT_W-1:0]        count_r;

    logic              full_s;
    logic              empty_s;
    logic              drain_now_s;
    logic              push_s;
    logic              merge_wr_s;
    logic              merge_hit_s;
    logic [PTR_W-1:0]  merge_idx_s;
    logic              fwd_hit_s;
    logic [DATA_W-1:0] fwd_data_s;
    logic [PTR_W-1:0]  unused_fwd_idx_s;

    wbuf_fwd_match #(.DEPTH(DEPTH)) u_fwd (
        .entries   (entries_r),
        .head      (head_r),
        .count     (count_r),
        .key       (ld_addr),
        .skip_head (1'b0),
        .hit       (fwd_hit_s),
        .data      (fwd_data_s),
        .idx       (unused_fwd_idx_s)
    );

`ifdef STORE_WBUF_MERGE_EN
    logic              merge_match_s;
    logic [DATA_W-1:0] unused_merge_data_s;

    // The head entry is excluded while it is being written out this cycle
    wbuf_fwd_match #(.DEPTH(DEPTH)) u_merge (
        .entries   (entries_r),
        .head      (head_r),
        .count     (count_r),
        .key       (st_addr),
        .skip_head (drain_now_s),
        .hit       (merge_match_s),
        .data      (unused_merge_data_s),
        .idx       (merge_idx_s)
    );

    assign merge_hit_s = st_valid && merge_match_s;
`else
    assign merge_hit_s = 1'b0;
    assign merge_idx_s = '0;
`endif

    // Occupancy flags and drain decision; the head drains whenever no load needs the port
    always_comb begin
        full_s      = (count_r == CNT_W'(DEPTH));
        empty_s     = (count_r == {CNT_W{1'b0}});
        drain_now_s = !empty_s && (!ld_valid || full_s || flush_req);
    end

    // Store handshake, load stall and forwarding select
    always_comb begin
        st_ready   = (!full_s || merge_hit_s) && !flush_req;
        push_s     = st_valid && st_ready && !merge_hit_s;
        merge_wr_s = merge_hit_s && !flush_req;
        ld_stall   = ld_valid && drain_now_s;
        flush_done = empty_s;
        if (ld_valid && !ld_stall && fwd_hit_s) begin
            ld_data = fwd_data_s;
        end else begin
            ld_data = mem_dout;
        end
    end

    // Memory port mux: the draining head owns the port, otherwise the load address is presented
    always_comb begin
        if (drain_now_s) begin
            mem_addr     = entries_r[head_r].addr;
            mem_datain   = entries_r[head_r].data;
            mem_write_en = 1'b1;
        end else if (ld_valid) begin
            mem_addr     = ld_addr;
            mem_datain   = {DATA_W{1'b0}};
            mem_write_en = 1'b0;
        end else begin
            mem_addr     = {ADDR_W{1'b0}};
            mem_datain   = {DATA_W{1'b0}};
            mem_write_en = 1'b0;
        end
    end

    // Entry storage, circular pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_r <= '0;
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
        end else begin
            if (push_s) begin
                entries_r[tail_r] <= '{addr: st_addr, data: st_data};
                tail_r            <= PTR_W'(wbuf_ptr_inc(8'(tail_r), 8'(DEPTH)));
            end else if (merge_wr_s) begin
                entries_r[merge_idx_s].data <= st_data;
            end else begin
                tail_r <= tail_r;
            end
            if (drain_now_s) begin
                head_r <= PTR_W'(wbuf_ptr_inc(8'(head_r), 8'(DEPTH)));
            end else begin
                head_r <= head_r;
            end
            case ({push_s, drain_now_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
